k12a_fetch_unit: RTL and testbench

Instruction fetch and sequencing stage directly upstream of the ALU.
- Owns the 16-bit program counter.
- Assembles each 16-bit instruction from two 8-bit memory reads, big-endian: high byte at PC, low byte at PC+1.
- Presents the instruction and is_skip to the ALU and control logic.
- Consumes alu_condition at the end of a skip-class instruction to nullify the following instruction.

---
 rtl/k12a_fetch_unit_pkg.sv | 19 +
 rtl/k12a_fetch_unit_if.sv | 15 +
 rtl/k12a_fetch_unit.sv | 125 ++++++++++++
 tb/tb_k12a_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/k12a_fetch_unit_pkg.sv
// Shared definitions for the K12A fetch/sequencing stage.
//   fetch_state_t     : fetch sequencer state encoding
//   K12A_OPCODE_SKIP  : 5-bit major opcode of the skip instruction class
//   is_skip_opcode()  : true when an instruction word belongs to the skip class
package k12a_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_STATE_HI      = 2'd0,
    FETCH_STATE_LO      = 2'd1,
    FETCH_STATE_EXECUTE = 2'd2
  } fetch_state_t;

  localparam logic [4:0] K12A_OPCODE_SKIP = 5'b10110;

  function automatic logic is_skip_opcode(input logic [15:0] word);
    return word[15:11] == K12A_OPCODE_SKIP;
  endfunction

endpackage

// File: rtl/k12a_fetch_unit_if.sv
// Byte-wide instruction memory read bus.
//   mem_addr  : byte address of the current read
//   mem_rd    : read request
//   mem_ready : read completes this cycle, mem_rdata valid
//   mem_rdata : read data
// master = fetch unit, slave = instruction memory.
interface k12a_fetch_unit_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [7:0]  mem_rdata;

  modport master (output mem_addr, mem_rd, input mem_ready, mem_rdata);
  modport slave  (input mem_addr, mem_rd, output mem_ready, mem_rdata);
endinterface

// File: rtl/k12a_fetch_unit.sv
// K12A instruction fetch and sequencing stage.
// Owns the program counter, assembles each 16-bit instruction from two
// big-endian byte reads (high byte at pc, low byte at pc+1), presents it to
// the ALU/control logic and nullifies the instruction following a taken skip.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   mem            : byte read bus (master side)
//   pc, inst       : program counter and instruction register
//   inst_valid     : instruction in EXECUTE and not nullified
//   is_skip        : valid instruction is of the skip class
//   exec_done      : control unit finished executing inst (EXECUTE only)
//   alu_condition  : condition result, sampled with exec_done
//   pc_load        : jump request, sampled with exec_done
//   pc_load_value  : jump target
module k12a_fetch_unit
  import k12a_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  k12a_fetch_unit_if.master         mem,
  output logic [15:0]               pc,
  output logic [15:0]               inst,
  output logic                      inst_valid,
  output logic                      is_skip,
  input  logic                      exec_done,
  input  logic                      alu_condition,
  input  logic                      pc_load,
  input  logic [15:0]               pc_load_value
);

  fetch_state_t state, state_next;
  logic [15:0]  pc_next;
  logic [15:0]  inst_next;
  logic [15:0]  pc_inc;
  logic         skip_pending, skip_next;
  logic         mem_rd_int;

  // Natural 16-bit overflow gives the required wrap from 16'hFFFF to 16'h0000.
  assign pc_inc       = pc + 16'd1;
  assign mem.mem_addr = pc;
  assign mem.mem_rd   = mem_rd_int;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    state_next = state;
    pc_next    = pc;
    inst_next  = inst;
    skip_next  = skip_pending;
    mem_rd_int = 1'b0;
    inst_valid = 1'b0;
    is_skip    = 1'b0;

    unique case (state)
      FETCH_STATE_HI: begin
        mem_rd_int = 1'b1;
        if (mem.mem_ready) begin
          inst_next[15:8] = mem.mem_rdata;
          pc_next         = pc_inc;
          state_next      = FETCH_STATE_LO;
        end
      end

      FETCH_STATE_LO: begin
        mem_rd_int = 1'b1;
        if (mem.mem_ready) begin
          inst_next[7:0] = mem.mem_rdata;
          pc_next        = pc_inc;
          state_next     = FETCH_STATE_EXECUTE;
        end
      end

      FETCH_STATE_EXECUTE: begin
        if (skip_pending) begin
          // Nullified slot: control inputs are ignored and the slot lasts one
          // cycle. Clearing skip_pending here stops a skipped skip from chaining.
          skip_next  = 1'b0;
          state_next = FETCH_STATE_HI;
        end else begin
          inst_valid = 1'b1;
          is_skip    = is_skip_opcode(inst);
          if (exec_done) begin
            state_next = FETCH_STATE_HI;
            if (pc_load) begin
              // A jump retargets the stream, so a pending skip is dropped.
              pc_next   = pc_load_value;
              skip_next = 1'b0;
            end else begin
              skip_next = is_skip && alu_condition;
            end
          end
        end
      end

      default: state_next = FETCH_STATE_HI;
    endcase

    // Outputs are forced idle while reset is asserted, even before the first
    // edge has cleared the state registers.
    if (!reset_n) begin
      mem_rd_int = 1'b0;
      inst_valid = 1'b0;
      is_skip    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values
    // regardless of statement order.
    if (!reset_n) begin
      state        <= FETCH_STATE_HI;
      pc           <= RESET_PC;
      inst         <= 16'h0000;
      skip_pending <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      inst         <= inst_next;
      skip_pending <= skip_next;
    end
  end

endmodule

// File: tb/tb_k12a_fetch_unit.sv
// Self-checking bench for k12a_fetch_unit: a directed cycle table, a reset
// sequence mid-fetch, and a randomized run against a transaction-level model.
module tb_k12a_fetch_unit;
  import k12a_fetch_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        tb_ready;
  logic [15:0] pc, inst, pc_load_value;
  logic        inst_valid, is_skip, exec_done, alu_condition, pc_load;
  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  k12a_fetch_unit_if bus ();
  assign bus.mem_ready = tb_ready;
  assign bus.mem_rdata = mem[bus.mem_addr];

  k12a_fetch_unit #(.RESET_PC(16'h0100)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .mem           (bus),
    .pc            (pc),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .is_skip       (is_skip),
    .exec_done     (exec_done),
    .alu_condition (alu_condition),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value)
  );

  typedef struct {
    logic        ready, done, cond, load;
    logic [15:0] load_val;
    logic        exp_rd;
    logic [15:0] exp_pc, exp_inst;
    logic        exp_valid, exp_skip;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, d, c, l, input logic [15:0] lv,
                             input logic rd, input logic [15:0] p, i,
                             input logic val, sk);
    vec_t x;
    x.ready = r; x.done = d; x.cond = c; x.load = l; x.load_val = lv;
    x.exp_rd = rd; x.exp_pc = p; x.exp_inst = i; x.exp_valid = val; x.exp_skip = sk;
    return x;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic r, d, c, l, input logic [15:0] lv);
    tb_ready = r; exec_done = d; alu_condition = c; pc_load = l; pc_load_value = lv;
  endtask

  // Transaction-level reference state for the randomized run.
  logic [15:0] mpc, a1, addr, exp_inst, jump;
  logic        mskip, exp_skip, ld, cond;
  int          w, d;

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0100] = 8'h12; mem[16'h0101] = 8'h34;
    mem[16'h0102] = 8'hB0; mem[16'h0103] = 8'h01;
    mem[16'h0104] = 8'h56; mem[16'h0105] = 8'h78;
    mem[16'h0106] = 8'hB0; mem[16'h0107] = 8'h02;
    mem[16'h0108] = 8'h9A; mem[16'h0109] = 8'hBC;
    mem[16'hFFFF] = 8'hB1; mem[16'h0000] = 8'h23;
    mem[16'h2000] = 8'h11; mem[16'h2001] = 8'h22; mem[16'h2002] = 8'h33;

    // Inputs for the cycle, then expected {mem_rd, pc/mem_addr, inst, inst_valid, is_skip}.
    vecs.push_back(v(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0100,16'h0000,1'b0,1'b0));
    vecs.push_back(v(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0101,16'h1200,1'b0,1'b0));
    vecs.push_back(v(1'b1,1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0102,16'h1234,1'b1,1'b0));
    vecs.push_back(v(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0102,16'h1234,1'b0,1'b0));
    vecs.push_back(v(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0103,16'hB034,1'b0,1'b0));
    vecs.push_back(v(1'b1,1'b1,1'b1,1'b0,16'h0000, 1'b0,16'h0104,16'hB001,1'b1,1'b1));
    vecs.push_back(v(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0104,16'hB001,1'b0,1'b0));
    vecs.push_back(v(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0105,16'h5601,1'b0,1'b0));
    vecs.push_back(v(1'b1,1'b1,1'b0,1'b1,16'h3000, 1'b0,16'h0106,16'h5678,1'b0,1'b0));
    vecs.push_back(v(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0106,16'h5678,1'b0,1'b0));
    vecs.push_back(v(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0107,16'hB078,1'b0,1'b0));
    vecs.push_back(v(1'b1,1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0108,16'hB002,1'b1,1'b1));
    vecs.push_back(v(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0108,16'hB002,1'b0,1'b0));
    vecs.push_back(v(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0109,16'h9A02,1'b0,1'b0));
    vecs.push_back(v(1'b1,1'b1,1'b0,1'b1,16'hFFFF, 1'b0,16'h010A,16'h9ABC,1'b1,1'b0));
    vecs.push_back(v(1'b0,1'b1,1'b1,1'b1,16'h4444, 1'b1,16'hFFFF,16'h9ABC,1'b0,1'b0));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'hFFFF,16'h9ABC,1'b0,1'b0));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'hFFFF,16'h9ABC,1'b0,1'b0));
    vecs.push_back(v(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'hFFFF,16'h9ABC,1'b0,1'b0));
    vecs.push_back(v(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0000,16'hB1BC,1'b0,1'b0));
    vecs.push_back(v(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0001,16'hB123,1'b1,1'b1));
    vecs.push_back(v(1'b1,1'b1,1'b1,1'b1,16'h2000, 1'b0,16'h0001,16'hB123,1'b1,1'b1));
    vecs.push_back(v(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h2000,16'hB123,1'b0,1'b0));
    vecs.push_back(v(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h2001,16'h1123,1'b0,1'b0));
    vecs.push_back(v(1'b1,1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h2002,16'h1122,1'b1,1'b0));
    vecs.push_back(v(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h2002,16'h1122,1'b0,1'b0));

    // Reset state.
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    check("reset_mem_rd", 16'(bus.mem_rd), 16'd0);
    check("reset_inst_valid", 16'(inst_valid), 16'd0);
    check("reset_pc", pc, 16'h0100);
    check("reset_inst", inst, 16'h0000);
    reset_n = 1'b1;

    // Directed cycle table.
    foreach (vecs[k]) begin
      drive(vecs[k].ready, vecs[k].done, vecs[k].cond, vecs[k].load, vecs[k].load_val);
      #1;
      check($sformatf("vec%0d_mem_rd", k), 16'(bus.mem_rd), 16'(vecs[k].exp_rd));
      check($sformatf("vec%0d_mem_addr", k), bus.mem_addr, vecs[k].exp_pc);
      check($sformatf("vec%0d_pc", k), pc, vecs[k].exp_pc);
      check($sformatf("vec%0d_inst", k), inst, vecs[k].exp_inst);
      check($sformatf("vec%0d_inst_valid", k), 16'(inst_valid), 16'(vecs[k].exp_valid));
      check($sformatf("vec%0d_is_skip", k), 16'(is_skip), 16'(vecs[k].exp_skip));
      tick();
    end

    // Reset asserted while in FETCH_LO (pc=2003) abandons the fetch.
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    check("midlo_rst_mem_rd", 16'(bus.mem_rd), 16'd0);
    check("midlo_rst_inst_valid", 16'(inst_valid), 16'd0);
    tick();
    check("midlo_pc", pc, 16'h0100);
    check("midlo_inst", inst, 16'h0000);
    check("midlo_inst_valid", 16'(inst_valid), 16'd0);
    reset_n = 1'b1;
    #1;
    check("midlo_refetch_rd", 16'(bus.mem_rd), 16'd1);
    check("midlo_refetch_addr", bus.mem_addr, 16'h0100);

    // Randomized run: random memory biased toward skip opcodes, random wait
    // states, execute delays, jumps and conditions.
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 8'($urandom);
      if ($urandom_range(2, 0) == 0) mem[a][7:3] = K12A_OPCODE_SKIP;
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    mpc   = 16'h0100;
    mskip = 1'b0;

    for (int n = 0; n < 120; n++) begin
      a1       = mpc + 16'd1;
      exp_inst = {mem[mpc], mem[a1]};
      for (int h = 0; h < 2; h++) begin
        addr = (h == 0) ? mpc : a1;
        w    = int'($urandom_range(2, 0));
        for (int k = 0; k <= w; k++) begin
          drive(k == w, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
          #1;
          check("rnd_fetch_rd", 16'(bus.mem_rd), 16'd1);
          check("rnd_fetch_addr", bus.mem_addr, addr);
          tick();
        end
      end
      mpc = mpc + 16'd2;

      if (mskip) begin
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
        #1;
        check("rnd_null_pc", pc, mpc);
        check("rnd_null_inst", inst, exp_inst);
        check("rnd_null_valid", 16'(inst_valid), 16'd0);
        check("rnd_null_skip", 16'(is_skip), 16'd0);
        tick();
        mskip = 1'b0;
      end else begin
        exp_skip = (exp_inst[15:11] == K12A_OPCODE_SKIP);
        d        = int'($urandom_range(2, 0));
        for (int k = 0; k <= d; k++) begin
          ld   = (k == d) && ($urandom_range(3, 0) == 0);
          cond = 1'($urandom);
          jump = 16'($urandom);
          drive(1'($urandom), k == d, cond, ld, jump);
          #1;
          check("rnd_exec_pc", pc, mpc);
          check("rnd_exec_inst", inst, exp_inst);
          check("rnd_exec_valid", 16'(inst_valid), 16'd1);
          check("rnd_exec_skip", 16'(is_skip), 16'(exp_skip));
          check("rnd_exec_rd", 16'(bus.mem_rd), 16'd0);
          tick();
        end
        if (ld) begin
          mpc   = jump;
          mskip = 1'b0;
        end else begin
          mskip = exp_skip && cond;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
